// File: rtl/hyper_lsab_dram.sv
// rtl/hyper_lsab_dram.sv - LSAB<->DRAM block-transfer command sequencer
//
// Purpose:
//   Accepts a block-transfer command (word address, length, LSAB section).
//   Opens the matching DRAM page in the memory controller when needed.
//   Issues a page-bounded request to the block movers.
//   Reports the words moved, the next address and a page-end flag.
//
// Ports:
//   CLK, RST             clock (rising edge); synchronous active-low reset
//   GO                   start command, sampled only while READY=1
//   BLOCK_LENGTH[5:0]    requested words, 0..63
//   NEW_ADDR[31:0]       start word address; [31:12] page, [11:0] column
//   NEW_SECTION[1:0]     LSAB section (FIFO index)
//   OLD_ADDR[31:0]       start address + words moved by the last command
//   READY                idle / last command complete
//   ENDOF_PAGE           last transfer ended exactly on a page boundary
//   COUNT_SENT[5:0]      words moved by the last command
//   BLCK_START[11:0]     column address to the block movers
//   BLCK_COUNT_REQ[5:0]  words requested from the block movers
//   BLCK_ISSUE           one-cycle start pulse to the block movers
//   BLCK_SECTION[1:0]    section to the block movers
//   BLCK_COUNT_SENT[5:0] words moved (OR of both movers)
//   BLCK_WORKING         mover busy (OR of both movers)
//   MCU_PAGE_ADDR[19:0]  page presented to the memory controller
//   MCU_REQUEST_ALIGN    page-align request, held until granted
//   MCU_GRANT_ALIGN      memory-controller grant

module hyper_lsab_dram #(
    parameter int WORK_TIMEOUT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        GO,
    input  logic [5:0]  BLOCK_LENGTH,
    input  logic [31:0] NEW_ADDR,
    input  logic [1:0]  NEW_SECTION,
    output logic [31:0] OLD_ADDR,
    output logic        READY,
    output logic        ENDOF_PAGE,
    output logic [5:0]  COUNT_SENT,
    output logic [11:0] BLCK_START,
    output logic [5:0]  BLCK_COUNT_REQ,
    output logic        BLCK_ISSUE,
    output logic [1:0]  BLCK_SECTION,
    input  logic [5:0]  BLCK_COUNT_SENT,
    input  logic        BLCK_WORKING,
    output logic [19:0] MCU_PAGE_ADDR,
    output logic        MCU_REQUEST_ALIGN,
    input  logic        MCU_GRANT_ALIGN
);

    localparam int TW = (WORK_TIMEOUT > 1) ? $clog2(WORK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [5:0]  r_req;
    logic [1:0]  r_section;
    logic [5:0]  r_count;
    logic        r_page_valid;
    logic [TW-1:0] r_timer;

    logic [31:0] r_old_addr;
    logic        r_ready;
    logic        r_endof_page;
    logic [5:0]  r_count_sent;
    logic [11:0] r_blck_start;
    logic [5:0]  r_blck_count_req;
    logic        r_blck_issue;
    logic [1:0]  r_blck_section;
    logic [19:0] r_mcu_page_addr;
    logic        r_mcu_request_align;

    // Words left in the page from the requested column; always >= 1.
    logic [12:0] w_room;
    logic [5:0]  w_req;
    logic        w_page_hit;
    logic [31:0] w_next_addr;

    assign w_room      = 13'd4096 - {1'b0, NEW_ADDR[11:0]};
    // room only drops below 64 near the page end, so its low 6 bits are exact there.
    assign w_req       = ({7'd0, BLOCK_LENGTH} < w_room) ? BLOCK_LENGTH : w_room[5:0];
    assign w_page_hit  = r_page_valid && (NEW_ADDR[31:12] == r_mcu_page_addr);
    assign w_next_addr = r_addr + {26'd0, r_count};

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state             <= S_IDLE;
            r_addr              <= '0;
            r_req               <= '0;
            r_section           <= '0;
            r_count             <= '0;
            r_page_valid        <= 1'b0;
            r_timer             <= '0;
            r_old_addr          <= '0;
            r_ready             <= 1'b1;
            r_endof_page        <= 1'b0;
            r_count_sent        <= '0;
            r_blck_start        <= '0;
            r_blck_count_req    <= '0;
            r_blck_issue        <= 1'b0;
            r_blck_section      <= '0;
            r_mcu_page_addr     <= '0;
            r_mcu_request_align <= 1'b0;
        end else begin
            r_blck_issue <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (GO) begin
                        r_addr    <= NEW_ADDR;
                        r_req     <= w_req;
                        r_section <= NEW_SECTION;
                        r_count   <= '0;
                        r_ready   <= 1'b0;
                        if (BLOCK_LENGTH == 6'd0) begin
                            r_state <= S_DONE;
                        end else if (!w_page_hit) begin
                            // Page and request go up together so the page is
                            // stable for the whole time the request is raised.
                            r_mcu_page_addr     <= NEW_ADDR[31:12];
                            r_mcu_request_align <= 1'b1;
                            r_state             <= S_ALIGN;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end

                S_ALIGN: begin
                    if (MCU_GRANT_ALIGN) begin
                        r_mcu_request_align <= 1'b0;
                        r_page_valid        <= 1'b1;
                        r_state             <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_blck_start     <= r_addr[11:0];
                    r_blck_count_req <= r_req;
                    r_blck_section   <= r_section;
                    r_blck_issue     <= 1'b1;
                    r_timer          <= '0;
                    r_state          <= S_WAIT_START;
                end

                S_WAIT_START: begin
                    if (BLCK_WORKING) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_timer == TW'(WORK_TIMEOUT - 1)) begin
                        // Movers never started (e.g. held in reset): report nothing moved.
                        r_count <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                S_WAIT_DONE: begin
                    if (!BLCK_WORKING) begin
                        r_count <= BLCK_COUNT_SENT;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_count_sent <= r_count;
                    r_old_addr   <= w_next_addr;
                    r_endof_page <= (r_count != 6'd0) && (w_next_addr[11:0] == 12'd0);
                    r_ready      <= 1'b1;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign OLD_ADDR          = r_old_addr;
    assign READY             = r_ready;
    assign ENDOF_PAGE        = r_endof_page;
    assign COUNT_SENT        = r_count_sent;
    assign BLCK_START        = r_blck_start;
    assign BLCK_COUNT_REQ    = r_blck_count_req;
    assign BLCK_ISSUE        = r_blck_issue;
    assign BLCK_SECTION      = r_blck_section;
    assign MCU_PAGE_ADDR     = r_mcu_page_addr;
    assign MCU_REQUEST_ALIGN = r_mcu_request_align;

endmodule

// File: tb/tb_hyper_lsab_dram.sv
// tb/tb_hyper_lsab_dram.sv - scoreboard bench for hyper_lsab_dram

module tb_hyper_lsab_dram;

    localparam int WORK_TIMEOUT = 8;

    logic        CLK;
    logic        RST;
    logic        GO;
    logic [5:0]  BLOCK_LENGTH;
    logic [31:0] NEW_ADDR;
    logic [1:0]  NEW_SECTION;
    logic [31:0] OLD_ADDR;
    logic        READY;
    logic        ENDOF_PAGE;
    logic [5:0]  COUNT_SENT;
    logic [11:0] BLCK_START;
    logic [5:0]  BLCK_COUNT_REQ;
    logic        BLCK_ISSUE;
    logic [1:0]  BLCK_SECTION;
    logic [5:0]  BLCK_COUNT_SENT;
    logic        BLCK_WORKING;
    logic [19:0] MCU_PAGE_ADDR;
    logic        MCU_REQUEST_ALIGN;
    logic        MCU_GRANT_ALIGN;

    hyper_lsab_dram #(.WORK_TIMEOUT(WORK_TIMEOUT)) dut (
        .CLK               (CLK),
        .RST               (RST),
        .GO                (GO),
        .BLOCK_LENGTH      (BLOCK_LENGTH),
        .NEW_ADDR          (NEW_ADDR),
        .NEW_SECTION       (NEW_SECTION),
        .OLD_ADDR          (OLD_ADDR),
        .READY             (READY),
        .ENDOF_PAGE        (ENDOF_PAGE),
        .COUNT_SENT        (COUNT_SENT),
        .BLCK_START        (BLCK_START),
        .BLCK_COUNT_REQ    (BLCK_COUNT_REQ),
        .BLCK_ISSUE        (BLCK_ISSUE),
        .BLCK_SECTION      (BLCK_SECTION),
        .BLCK_COUNT_SENT   (BLCK_COUNT_SENT),
        .BLCK_WORKING      (BLCK_WORKING),
        .MCU_PAGE_ADDR     (MCU_PAGE_ADDR),
        .MCU_REQUEST_ALIGN (MCU_REQUEST_ALIGN),
        .MCU_GRANT_ALIGN   (MCU_GRANT_ALIGN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] old_addr;
        logic [5:0]  count;
        logic        eop;
    } result_t;

    result_t sb[$];
    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [31:0] addr, input logic [5:0] len, input logic [1:0] sec,
                           input int gdel, input int work, input logic [5:0] ret,
                           input bit never, input bit exp_align, input int abort_at);
        result_t     e;
        result_t     got;
        logic [12:0] room;
        logic [5:0]  req;
        int          cyc;
        int          wait_cyc;
        int          issues;
        int          issue_cyc;
        int          gcnt;
        int          work_left;
        bit          align_seen;
        bit          done;

        room = 13'd4096 - {1'b0, addr[11:0]};
        req  = ({7'd0, len} < room) ? len : room[5:0];
        e.count    = (len == 6'd0 || never) ? 6'd0 : ret;
        e.old_addr = addr + {26'd0, e.count};
        e.eop      = (e.count != 6'd0) && (e.old_addr[11:0] == 12'd0);
        sb.push_back(e);

        wait_cyc = 0;
        while (!READY && wait_cyc < 100) begin
            @(posedge CLK); #1;
            wait_cyc++;
        end
        if (!READY) chk("ready_before_go", 64'(READY), 64'd1);

        GO = 1'b1; NEW_ADDR = addr; BLOCK_LENGTH = len; NEW_SECTION = sec;
        @(posedge CLK); #1;
        GO = 1'b0;

        cyc = 0; issues = 0; issue_cyc = 0; gcnt = 0; work_left = 0;
        align_seen = 1'b0; done = 1'b0;
        while (!done && cyc < 300) begin
            @(posedge CLK); #1;
            cyc++;
            // A stray GO while busy must be ignored.
            if (cyc == 2 && !READY) begin
                GO = 1'b1; NEW_ADDR = ~addr; BLOCK_LENGTH = 6'd1;
            end else begin
                GO = 1'b0;
            end

            if (work_left > 0) begin
                work_left--;
                if (work_left == 0) begin
                    BLCK_WORKING    = 1'b0;
                    BLCK_COUNT_SENT = ret;
                end
            end

            if (MCU_REQUEST_ALIGN) begin
                align_seen = 1'b1;
                chk("align_page", 64'(MCU_PAGE_ADDR), 64'(addr[31:12]));
                gcnt++;
                MCU_GRANT_ALIGN = (gcnt >= gdel);
            end else begin
                MCU_GRANT_ALIGN = 1'b0;
            end

            if (BLCK_ISSUE) begin
                issues++;
                issue_cyc = cyc;
                chk("blck_start", 64'(BLCK_START), 64'(addr[11:0]));
                chk("blck_count_req", 64'(BLCK_COUNT_REQ), 64'(req));
                chk("blck_section", 64'(BLCK_SECTION), 64'(sec));
                if (!never) begin
                    BLCK_WORKING = 1'b1;
                    work_left    = (work < 1) ? 1 : work;
                end
            end

            if (abort_at > 0 && issues > 0 && cyc == issue_cyc + abort_at) begin
                RST = 1'b0;
                @(posedge CLK); #1;
                chk("abort_ready", 64'(READY), 64'd1);
                chk("abort_req_align", 64'(MCU_REQUEST_ALIGN), 64'd0);
                chk("abort_issue", 64'(BLCK_ISSUE), 64'd0);
                chk("abort_old_addr", 64'(OLD_ADDR), 64'd0);
                RST = 1'b1;
                BLCK_WORKING = 1'b0;
                MCU_GRANT_ALIGN = 1'b0;
                void'(sb.pop_back());
                done = 1'b1;
            end else if (READY) begin
                done = 1'b1;
                if (sb.size() == 0) begin
                    chk("sb_empty", 64'd1, 64'd0);
                end else begin
                    got = sb.pop_front();
                    chk("old_addr", 64'(OLD_ADDR), 64'(got.old_addr));
                    chk("count_sent", 64'(COUNT_SENT), 64'(got.count));
                    chk("endof_page", 64'(ENDOF_PAGE), 64'(got.eop));
                end
                chk("issue_pulses", 64'(issues), (len == 6'd0) ? 64'd0 : 64'd1);
                chk("align_seen", 64'(align_seen), 64'(exp_align));
                if (len == 6'd0) chk("len0_latency", 64'(cyc <= 3), 64'd1);
                if (never) chk("timeout_wait", 64'((cyc - issue_cyc) >= WORK_TIMEOUT), 64'd1);
            end
        end
        if (!done) chk("cmd_timeout", 64'd0, 64'd1);
        GO = 1'b0;
        MCU_GRANT_ALIGN = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        RST = 1'b0; GO = 1'b0; BLOCK_LENGTH = '0; NEW_ADDR = '0; NEW_SECTION = '0;
        BLCK_COUNT_SENT = '0; BLCK_WORKING = 1'b0; MCU_GRANT_ALIGN = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            chk("rst_ready", 64'(READY), 64'd1);
            chk("rst_req_align", 64'(MCU_REQUEST_ALIGN), 64'd0);
            chk("rst_issue", 64'(BLCK_ISSUE), 64'd0);
            chk("rst_old_addr", 64'(OLD_ADDR), 64'd0);
        end

        //      addr          len    sec  gdel work ret   never align abort
        run_cmd(32'h0000_3010, 6'd16, 2'd1, 3, 20, 6'd16, 1'b0, 1'b1, 0);
        run_cmd(32'h0000_3020, 6'd8,  2'd2, 3, 5,  6'd8,  1'b0, 1'b0, 0);
        run_cmd(32'h0000_4FF8, 6'd32, 2'd3, 1, 6,  6'd8,  1'b0, 1'b1, 0);
        run_cmd(32'h1234_5678, 6'd0,  2'd0, 1, 1,  6'd0,  1'b0, 1'b0, 0);
        run_cmd(32'h0000_4100, 6'd10, 2'd1, 1, 1,  6'd0,  1'b1, 1'b0, 0);
        run_cmd(32'h0000_4200, 6'd4,  2'd0, 1, 3,  6'd6,  1'b0, 1'b0, 0);
        run_cmd(32'hFFFF_FFF0, 6'd40, 2'd2, 2, 4,  6'd16, 1'b0, 1'b1, 0);
        run_cmd(32'h0000_7000, 6'd20, 2'd1, 2, 30, 6'd20, 1'b0, 1'b1, 5);
        run_cmd(32'h0000_0040, 6'd4,  2'd3, 2, 3,  6'd4,  1'b0, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
